// File: rtl/hpdcache_pkg.sv
// Shared request/response types for the HPDcache core-side request arbiter.
package hpdcache_pkg;
    localparam int unsigned HPDCACHE_ARB_MAX_REQ = 16;
    localparam int unsigned HPDCACHE_SID_WIDTH   = 4;

    typedef logic [HPDCACHE_SID_WIDTH-1:0] hpdcache_sid_t;
    typedef logic [23:0]                   hpdcache_tag_t;

    typedef struct packed {
        logic [15:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    op;
        hpdcache_sid_t sid;
        logic [3:0]    tid;
    } hpdcache_req_t;

    typedef struct packed {
        logic uncacheable;
        logic io;
    } hpdcache_pma_t;

    typedef struct packed {
        logic [31:0]   rdata;
        hpdcache_sid_t sid;
        logic [3:0]    tid;
        logic          error;
    } hpdcache_rsp_t;
endpackage

// File: rtl/hpdcache_core_arbiter_rr_if.sv
// Bundle of core-side requester ports and the cache-side request/response ports.
interface hpdcache_core_arbiter_rr_if
    import hpdcache_pkg::*;
#(
    parameter int unsigned NREQUESTERS = 2
);
    // Handshake: a request transfers on a cycle where valid and ready are both high;
    // once valid is raised the requester holds valid and the request stable until ready.
    logic          [NREQUESTERS-1:0] core_req_valid_i;
    logic          [NREQUESTERS-1:0] core_req_ready_o;
    hpdcache_req_t [NREQUESTERS-1:0] core_req_i;
    logic          [NREQUESTERS-1:0] core_req_abort_i;
    hpdcache_tag_t [NREQUESTERS-1:0] core_req_tag_i;
    hpdcache_pma_t [NREQUESTERS-1:0] core_req_pma_i;
    logic                            core_rsp_valid_i;
    hpdcache_rsp_t                   core_rsp_i;
    logic          [NREQUESTERS-1:0] core_rsp_valid_o;
    hpdcache_rsp_t [NREQUESTERS-1:0] core_rsp_o;
    logic                            arb_req_valid_o;
    logic                            arb_req_ready_i;
    hpdcache_req_t                   arb_req_o;
    logic                            arb_req2_valid_o;
    logic                            arb_abort_o;
    hpdcache_tag_t                   arb_tag_o;
    hpdcache_pma_t                   arb_pma_o;

    modport slave (
        input  core_req_valid_i, core_req_i, core_req_abort_i, core_req_tag_i, core_req_pma_i,
               core_rsp_valid_i, core_rsp_i, arb_req_ready_i,
        output core_req_ready_o, core_rsp_valid_o, core_rsp_o, arb_req_valid_o, arb_req_o,
               arb_req2_valid_o, arb_abort_o, arb_tag_o, arb_pma_o
    );

    modport master (
        output core_req_valid_i, core_req_i, core_req_abort_i, core_req_tag_i, core_req_pma_i,
               core_rsp_valid_i, core_rsp_i, arb_req_ready_i,
        input  core_req_ready_o, core_rsp_valid_o, core_rsp_o, arb_req_valid_o, arb_req_o,
               arb_req2_valid_o, arb_abort_o, arb_tag_o, arb_pma_o
    );
endinterface

// File: rtl/hpdcache_mux.sv
// Generic N-input mux, selected either by a one-hot vector or by a binary index.
module hpdcache_mux #(
    parameter int unsigned NINPUT      = 2,
    parameter int unsigned DATA_WIDTH  = 1,
    parameter bit          ONE_HOT_SEL = 1'b1,
    localparam int unsigned SEL_W      = ONE_HOT_SEL ? NINPUT : ((NINPUT > 1) ? $clog2(NINPUT) : 1)
) (
    input  logic [SEL_W-1:0]                 sel_i,
    input  logic [NINPUT-1:0][DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0]            data_o
);
    generate
        if (ONE_HOT_SEL) begin : g_onehot
            // An all-zero select yields all-zero data.
            always_comb begin
                data_o = '0;
                for (int i = 0; i < NINPUT; i++) begin
                    if (sel_i[i]) data_o = data_o | data_i[i];
                end
            end
        end else begin : g_binary
            always_comb begin
                data_o = '0;
                for (int i = 0; i < NINPUT; i++) begin
                    if (SEL_W'(i) == sel_i) data_o = data_i[i];
                end
            end
        end
    endgenerate
endmodule

// File: rtl/hpdcache_rrarb.sv
// Priority search (fixed or round-robin from a rotating pointer) with grant hold while stalled.
module hpdcache_rrarb #(
    parameter int unsigned N       = 2,
    parameter bit          RR_MODE = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         ready_i,
    output logic [N-1:0] gnt_o
);
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [N-1:0]     r_hold;
    logic             r_hold_v;
    logic [N-1:0]     w_search;
    logic [N-1:0]     w_gnt;
    logic [PTR_W-1:0] w_idx;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_accept;
    logic             w_stall;

    always_comb begin
        int unsigned j;
        logic        found;
        w_search = '0;
        found    = 1'b0;
        j        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(r_ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req_i[PTR_W'(j)]) begin
                w_search[PTR_W'(j)] = 1'b1;
                found               = 1'b1;
            end
        end
    end

    assign w_gnt    = r_hold_v ? r_hold : w_search;
    assign gnt_o    = w_gnt;
    assign w_accept = (|w_gnt) & ready_i;
    assign w_stall  = (|w_gnt) & ~ready_i;

    always_comb begin
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt[k]) w_idx = PTR_W'(k);
        end
    end

    assign w_ptr_nxt = (w_idx == PTR_W'(N - 1)) ? '0 : w_idx + 1'b1;

    // Fixed-priority mode never moves the pointer, so the search always starts at 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr    <= '0;
            r_hold   <= '0;
            r_hold_v <= 1'b0;
        end else begin
            r_hold_v <= w_stall;
            r_hold   <= w_stall ? w_gnt : '0;
            if (RR_MODE && w_accept) r_ptr <= w_ptr_nxt;
        end
    end
endmodule

// File: rtl/hpdcache_core_arbiter_rr.sv
// Core-side request arbiter: grants one requester, muxes its second-cycle fields, routes responses by sid.
module hpdcache_core_arbiter_rr
    import hpdcache_pkg::*;
#(
    parameter int unsigned NREQUESTERS = 2,
    parameter bit          RR_MODE     = 1'b1,
    parameter bit          RSP_REG     = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    hpdcache_core_arbiter_rr_if.slave  io
);
    localparam int unsigned REQ_W  = $bits(hpdcache_req_t);
    localparam int unsigned REQ2_W = 1 + $bits(hpdcache_tag_t) + $bits(hpdcache_pma_t);

    logic [NREQUESTERS-1:0]             w_gnt;
    logic [NREQUESTERS-1:0]             r_gnt;
    logic                               w_accept;
    logic [REQ_W-1:0]                   w_req;
    logic [NREQUESTERS-1:0][REQ2_W-1:0] w_req2_data;
    logic [REQ2_W-1:0]                  w_req2;
    logic [NREQUESTERS-1:0]             w_rsp_valid;
    logic [NREQUESTERS-1:0]             w_rsp_valid_out;
    hpdcache_rsp_t                      w_rsp_out;

    hpdcache_rrarb #(.N(NREQUESTERS), .RR_MODE(RR_MODE)) u_rrarb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (io.core_req_valid_i),
        .ready_i (io.arb_req_ready_i),
        .gnt_o   (w_gnt)
    );

    assign w_accept            = (|w_gnt) & io.arb_req_ready_i;
    assign io.arb_req_valid_o  = |w_gnt;
    assign io.core_req_ready_o = w_gnt & {NREQUESTERS{io.arb_req_ready_i}};

    hpdcache_mux #(.NINPUT(NREQUESTERS), .DATA_WIDTH(REQ_W), .ONE_HOT_SEL(1'b1)) u_req_mux (
        .sel_i  (w_gnt),
        .data_i (io.core_req_i),
        .data_o (w_req)
    );
    assign io.arb_req_o = w_req;

    // r_gnt remembers who was accepted so the following cycle can pick up its abort/tag/PMA.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_gnt <= '0;
        else       r_gnt <= w_accept ? w_gnt : '0;
    end

    always_comb begin
        w_req2_data = '0;
        for (int i = 0; i < NREQUESTERS; i++) begin
            w_req2_data[i] = {io.core_req_abort_i[i], io.core_req_tag_i[i], io.core_req_pma_i[i]};
        end
    end

    hpdcache_mux #(.NINPUT(NREQUESTERS), .DATA_WIDTH(REQ2_W), .ONE_HOT_SEL(1'b1)) u_req2_mux (
        .sel_i  (r_gnt),
        .data_i (w_req2_data),
        .data_o (w_req2)
    );
    assign io.arb_req2_valid_o = |r_gnt;
    assign {io.arb_abort_o, io.arb_tag_o, io.arb_pma_o} = w_req2;

    // A sid outside 0..NREQUESTERS-1 matches no port and is dropped.
    always_comb begin
        w_rsp_valid = '0;
        for (int i = 0; i < NREQUESTERS; i++) begin
            w_rsp_valid[i] = io.core_rsp_valid_i && (io.core_rsp_i.sid == HPDCACHE_SID_WIDTH'(i));
        end
    end

    generate
        if (RSP_REG) begin : g_rsp_reg
            logic [NREQUESTERS-1:0] r_rsp_valid;
            hpdcache_rsp_t          r_rsp;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_rsp_valid <= '0;
                    r_rsp       <= '0;
                end else begin
                    r_rsp_valid <= w_rsp_valid;
                    if (io.core_rsp_valid_i) r_rsp <= io.core_rsp_i;
                end
            end
            assign w_rsp_valid_out = r_rsp_valid;
            assign w_rsp_out       = r_rsp;
        end else begin : g_rsp_comb
            assign w_rsp_valid_out = w_rsp_valid;
            assign w_rsp_out       = io.core_rsp_i;
        end
    endgenerate

    assign io.core_rsp_valid_o = w_rsp_valid_out;
    always_comb begin
        io.core_rsp_o = '0;
        for (int i = 0; i < NREQUESTERS; i++) io.core_rsp_o[i] = w_rsp_out;
    end
endmodule

// File: tb/tb_hpdcache_core_arbiter_rr.sv
// Directed bench: a round-robin/registered-response instance and a fixed-priority/combinational one.
module tb_hpdcache_core_arbiter_rr;
    import hpdcache_pkg::*;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    hpdcache_core_arbiter_rr_if #(.NREQUESTERS(N)) if_rr ();
    hpdcache_core_arbiter_rr_if #(.NREQUESTERS(N)) if_fp ();

    hpdcache_core_arbiter_rr #(.NREQUESTERS(N), .RR_MODE(1'b1), .RSP_REG(1'b1)) dut_rr (
        .clk_i (clk),
        .rst_i (rst),
        .io    (if_rr)
    );

    hpdcache_core_arbiter_rr #(.NREQUESTERS(N), .RR_MODE(1'b0), .RSP_REG(1'b0)) dut_fp (
        .clk_i (clk),
        .rst_i (rst),
        .io    (if_fp)
    );

    // A stalled request must stay presented unchanged until it is accepted.
    logic          r_stall;
    hpdcache_req_t r_stall_req;
    always @(posedge clk) begin
        if (rst) begin
            r_stall <= 1'b0;
        end else begin
            if (r_stall) begin
                assert (if_rr.arb_req_valid_o && if_rr.arb_req_o == r_stall_req)
                    else $error("FAIL protocol_hold: stalled request changed before ready");
            end
            r_stall     <= if_rr.arb_req_valid_o && !if_rr.arb_req_ready_i;
            r_stall_req <= if_rr.arb_req_o;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (dut_rr.u_rrarb.r_ptr !== 2'd0) $display("FAIL reset_ptr: got %0d want 0", dut_rr.u_rrarb.r_ptr); else n_pass++;
        n_checks++; if (dut_rr.u_rrarb.r_hold_v !== 1'b0) $display("FAIL reset_hold_v: got %b want 0", dut_rr.u_rrarb.r_hold_v); else n_pass++;
        n_checks++; if (dut_rr.r_gnt !== 4'b0000) $display("FAIL reset_gnt_q: got %b want 0000", dut_rr.r_gnt); else n_pass++;
        n_checks++; if (if_rr.arb_req2_valid_o !== 1'b0) $display("FAIL reset_req2_valid: got %b want 0", if_rr.arb_req2_valid_o); else n_pass++;
        n_checks++; if (if_rr.core_rsp_valid_o !== 4'b0000) $display("FAIL reset_rsp_valid: got %b want 0000", if_rr.core_rsp_valid_o); else n_pass++;
        n_checks++; if (if_rr.core_rsp_o[2] !== '0) $display("FAIL reset_rsp_data: got %h want 0", if_rr.core_rsp_o[2]); else n_pass++;
        n_checks++; if (if_rr.arb_req_valid_o !== 1'b0) $display("FAIL reset_arb_valid: got %b want 0", if_rr.arb_req_valid_o); else n_pass++;
    endtask

    task automatic test_rr_rotation();
        logic [3:0] gnt_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [15:0] addr_seq [5] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0100};
        logic [1:0] ptr_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        cyc();
        if_rr.core_req_valid_i = 4'b1111;
        if_rr.arb_req_ready_i  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_checks++; if (if_rr.core_req_ready_o !== gnt_seq[k]) $display("FAIL rr_grant[%0d]: got %b want %b", k, if_rr.core_req_ready_o, gnt_seq[k]); else n_pass++;
            n_checks++; if (if_rr.arb_req_o.addr !== addr_seq[k]) $display("FAIL rr_addr[%0d]: got %h want %h", k, if_rr.arb_req_o.addr, addr_seq[k]); else n_pass++;
            cyc();
            n_checks++; if (dut_rr.u_rrarb.r_ptr !== ptr_seq[k]) $display("FAIL rr_ptr[%0d]: got %0d want %0d", k, dut_rr.u_rrarb.r_ptr, ptr_seq[k]); else n_pass++;
        end
        if_rr.core_req_valid_i = 4'b0000;
    endtask

    task automatic test_stall_hold();
        if_rr.arb_req_ready_i  = 1'b0;
        if_rr.core_req_valid_i = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (if_rr.arb_req_o.addr !== 16'h0102) $display("FAIL stall_addr[%0d]: got %h want 0102", c, if_rr.arb_req_o.addr); else n_pass++;
            n_checks++; if (if_rr.core_req_ready_o !== 4'b0000) $display("FAIL stall_ready[%0d]: got %b want 0000", c, if_rr.core_req_ready_o); else n_pass++;
            cyc();
            if (c == 0) if_rr.core_req_valid_i = 4'b1101;
            n_checks++; if (dut_rr.u_rrarb.r_hold_v !== 1'b1) $display("FAIL stall_hold_v[%0d]: got %b want 1", c, dut_rr.u_rrarb.r_hold_v); else n_pass++;
        end
        if_rr.arb_req_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (if_rr.core_req_ready_o !== 4'b0100) $display("FAIL stall_accept: got %b want 0100", if_rr.core_req_ready_o); else n_pass++;
        cyc();
        if_rr.core_req_valid_i = 4'b1001;
        n_checks++; if (dut_rr.u_rrarb.r_ptr !== 2'd3) $display("FAIL stall_ptr: got %0d want 3", dut_rr.u_rrarb.r_ptr); else n_pass++;
        n_checks++; if (dut_rr.u_rrarb.r_hold_v !== 1'b0) $display("FAIL stall_hold_clear: got %b want 0", dut_rr.u_rrarb.r_hold_v); else n_pass++;
        @(negedge clk);
        n_checks++; if (if_rr.core_req_ready_o !== 4'b1000) $display("FAIL stall_next3: got %b want 1000", if_rr.core_req_ready_o); else n_pass++;
        cyc();
        if_rr.core_req_valid_i = 4'b0001;
        n_checks++; if (dut_rr.u_rrarb.r_ptr !== 2'd0) $display("FAIL stall_ptr_wrap: got %0d want 0", dut_rr.u_rrarb.r_ptr); else n_pass++;
        @(negedge clk);
        n_checks++; if (if_rr.core_req_ready_o !== 4'b0001) $display("FAIL stall_next0: got %b want 0001", if_rr.core_req_ready_o); else n_pass++;
        cyc();
        if_rr.core_req_valid_i = 4'b0000;
    endtask

    task automatic test_second_cycle();
        @(negedge clk);
        n_checks++; if (if_rr.arb_req2_valid_o !== 1'b1) $display("FAIL req2_after0_valid: got %b want 1", if_rr.arb_req2_valid_o); else n_pass++;
        n_checks++; if (if_rr.arb_tag_o !== 24'h000033) $display("FAIL req2_after0_tag: got %h want 000033", if_rr.arb_tag_o); else n_pass++;
        cyc();
        @(negedge clk);
        n_checks++; if (if_rr.arb_req2_valid_o !== 1'b0) $display("FAIL req2_idle_valid: got %b want 0", if_rr.arb_req2_valid_o); else n_pass++;
        n_checks++; if (if_rr.arb_tag_o !== 24'h0) $display("FAIL req2_idle_tag: got %h want 0", if_rr.arb_tag_o); else n_pass++;
        if_rr.core_req_valid_i = 4'b0010;
        #1;
        n_checks++; if (if_rr.core_req_ready_o !== 4'b0010) $display("FAIL req2_grant1: got %b want 0010", if_rr.core_req_ready_o); else n_pass++;
        cyc();
        if_rr.core_req_valid_i    = 4'b0000;
        if_rr.core_req_tag_i[1]   = 24'h00005A;
        if_rr.core_req_abort_i[1] = 1'b1;
        if_rr.core_req_pma_i[1]   = '{uncacheable: 1'b1, io: 1'b0};
        @(negedge clk);
        n_checks++; if (if_rr.arb_req2_valid_o !== 1'b1) $display("FAIL req2_valid: got %b want 1", if_rr.arb_req2_valid_o); else n_pass++;
        n_checks++; if (if_rr.arb_tag_o !== 24'h00005A) $display("FAIL req2_tag: got %h want 00005a", if_rr.arb_tag_o); else n_pass++;
        n_checks++; if (if_rr.arb_abort_o !== 1'b1) $display("FAIL req2_abort: got %b want 1", if_rr.arb_abort_o); else n_pass++;
        n_checks++; if (if_rr.arb_pma_o !== 2'b10) $display("FAIL req2_pma: got %b want 10", if_rr.arb_pma_o); else n_pass++;
        cyc();
        @(negedge clk);
        n_checks++; if (if_rr.arb_req2_valid_o !== 1'b0) $display("FAIL req2_one_cycle: got %b want 0", if_rr.arb_req2_valid_o); else n_pass++;
        n_checks++; if (if_rr.arb_abort_o !== 1'b0) $display("FAIL req2_abort_zero: got %b want 0", if_rr.arb_abort_o); else n_pass++;
        n_checks++; if (if_rr.arb_tag_o !== 24'h0) $display("FAIL req2_tag_zero: got %h want 0", if_rr.arb_tag_o); else n_pass++;
        if_rr.core_req_abort_i[1] = 1'b0;
    endtask

    task automatic test_rsp_routing();
        cyc();
        if_rr.core_rsp_valid_i = 1'b1;
        if_rr.core_rsp_i       = '{rdata: 32'hDEADBEEF, sid: 4'd2, tid: 4'd5, error: 1'b0};
        @(negedge clk);
        n_checks++; if (if_rr.core_rsp_valid_o !== 4'b0000) $display("FAIL rsp_latency: got %b want 0000", if_rr.core_rsp_valid_o); else n_pass++;
        cyc();
        if_rr.core_rsp_i = '{rdata: 32'h12345678, sid: 4'd7, tid: 4'd6, error: 1'b0};
        @(negedge clk);
        n_checks++; if (if_rr.core_rsp_valid_o !== 4'b0100) $display("FAIL rsp_sid2_valid: got %b want 0100", if_rr.core_rsp_valid_o); else n_pass++;
        n_checks++; if (if_rr.core_rsp_o[0].rdata !== 32'hDEADBEEF) $display("FAIL rsp_bcast0: got %h want deadbeef", if_rr.core_rsp_o[0].rdata); else n_pass++;
        n_checks++; if (if_rr.core_rsp_o[3].tid !== 4'd5) $display("FAIL rsp_bcast3_tid: got %0d want 5", if_rr.core_rsp_o[3].tid); else n_pass++;
        cyc();
        if_rr.core_rsp_valid_i = 1'b0;
        if_rr.core_rsp_i       = '{rdata: 32'hAAAA5555, sid: 4'd1, tid: 4'd0, error: 1'b1};
        @(negedge clk);
        n_checks++; if (if_rr.core_rsp_valid_o !== 4'b0000) $display("FAIL rsp_sid7_valid: got %b want 0000", if_rr.core_rsp_valid_o); else n_pass++;
        n_checks++; if (if_rr.core_rsp_o[1].rdata !== 32'h12345678) $display("FAIL rsp_b2b_data: got %h want 12345678", if_rr.core_rsp_o[1].rdata); else n_pass++;
        cyc();
        @(negedge clk);
        n_checks++; if (if_rr.core_rsp_valid_o !== 4'b0000) $display("FAIL rsp_idle_valid: got %b want 0000", if_rr.core_rsp_valid_o); else n_pass++;
        n_checks++; if (if_rr.core_rsp_o[1].rdata !== 32'h12345678) $display("FAIL rsp_data_hold: got %h want 12345678", if_rr.core_rsp_o[1].rdata); else n_pass++;
    endtask

    task automatic test_fixed_priority();
        cyc();
        if_fp.core_req_valid_i = 4'b1010;
        if_fp.arb_req_ready_i  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if (if_fp.core_req_ready_o !== 4'b0010) $display("FAIL fp_grant1[%0d]: got %b want 0010", c, if_fp.core_req_ready_o); else n_pass++;
            n_checks++; if (if_fp.arb_req_o.addr !== 16'h0201) $display("FAIL fp_addr[%0d]: got %h want 0201", c, if_fp.arb_req_o.addr); else n_pass++;
            cyc();
        end
        n_checks++; if (dut_fp.u_rrarb.r_ptr !== 2'd0) $display("FAIL fp_ptr: got %0d want 0", dut_fp.u_rrarb.r_ptr); else n_pass++;
        if_fp.arb_req_ready_i = 1'b0;
        @(negedge clk);
        n_checks++; if (if_fp.core_req_ready_o !== 4'b0000) $display("FAIL fp_stall_ready: got %b want 0000", if_fp.core_req_ready_o); else n_pass++;
        n_checks++; if (if_fp.arb_req_valid_o !== 1'b1) $display("FAIL fp_stall_valid: got %b want 1", if_fp.arb_req_valid_o); else n_pass++;
        cyc();
        if_fp.arb_req_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (if_fp.core_req_ready_o !== 4'b0010) $display("FAIL fp_after_stall: got %b want 0010", if_fp.core_req_ready_o); else n_pass++;
        cyc();
        if_fp.core_req_valid_i = 4'b1000;
        @(negedge clk);
        n_checks++; if (if_fp.core_req_ready_o !== 4'b1000) $display("FAIL fp_grant3: got %b want 1000", if_fp.core_req_ready_o); else n_pass++;
        cyc();
        if_fp.core_req_valid_i = 4'b0000;
        n_checks++; if (dut_fp.u_rrarb.r_ptr !== 2'd0) $display("FAIL fp_ptr_end: got %0d want 0", dut_fp.u_rrarb.r_ptr); else n_pass++;
        if_fp.core_rsp_valid_i = 1'b1;
        if_fp.core_rsp_i       = '{rdata: 32'hCAFEF00D, sid: 4'd3, tid: 4'd1, error: 1'b0};
        #1;
        n_checks++; if (if_fp.core_rsp_valid_o !== 4'b1000) $display("FAIL fp_rsp_sid3: got %b want 1000", if_fp.core_rsp_valid_o); else n_pass++;
        n_checks++; if (if_fp.core_rsp_o[0].rdata !== 32'hCAFEF00D) $display("FAIL fp_rsp_data: got %h want cafef00d", if_fp.core_rsp_o[0].rdata); else n_pass++;
        if_fp.core_rsp_i.sid = 4'd7;
        #1;
        n_checks++; if (if_fp.core_rsp_valid_o !== 4'b0000) $display("FAIL fp_rsp_sid7: got %b want 0000", if_fp.core_rsp_valid_o); else n_pass++;
        if_fp.core_rsp_valid_i = 1'b0;
    endtask

    task automatic test_reset_during_stall();
        cyc();
        if_rr.arb_req_ready_i  = 1'b0;
        if_rr.core_req_valid_i = 4'b1000;
        @(negedge clk);
        n_checks++; if (if_rr.arb_req_o.addr !== 16'h0103) $display("FAIL rst_stall_addr: got %h want 0103", if_rr.arb_req_o.addr); else n_pass++;
        cyc();
        if_rr.core_req_valid_i = 4'b1001;
        n_checks++; if (dut_rr.u_rrarb.r_hold_v !== 1'b1) $display("FAIL rst_stall_hold_v: got %b want 1", dut_rr.u_rrarb.r_hold_v); else n_pass++;
        @(negedge clk);
        n_checks++; if (if_rr.arb_req_o.addr !== 16'h0103) $display("FAIL rst_stall_held: got %h want 0103", if_rr.arb_req_o.addr); else n_pass++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++; if (dut_rr.u_rrarb.r_ptr !== 2'd0) $display("FAIL rst_mid_ptr: got %0d want 0", dut_rr.u_rrarb.r_ptr); else n_pass++;
        n_checks++; if (dut_rr.u_rrarb.r_hold_v !== 1'b0) $display("FAIL rst_mid_hold_v: got %b want 0", dut_rr.u_rrarb.r_hold_v); else n_pass++;
        n_checks++; if (dut_rr.u_rrarb.r_hold !== 4'b0000) $display("FAIL rst_mid_hold: got %b want 0000", dut_rr.u_rrarb.r_hold); else n_pass++;
        n_checks++; if (dut_rr.r_gnt !== 4'b0000) $display("FAIL rst_mid_gnt_q: got %b want 0000", dut_rr.r_gnt); else n_pass++;
        @(negedge clk);
        n_checks++; if (if_rr.arb_req_o.addr !== 16'h0100) $display("FAIL rst_mid_regrant: got %h want 0100", if_rr.arb_req_o.addr); else n_pass++;
        n_checks++; if (if_rr.arb_req2_valid_o !== 1'b0) $display("FAIL rst_mid_req2: got %b want 0", if_rr.arb_req2_valid_o); else n_pass++;
        if_rr.arb_req_ready_i = 1'b1;
        cyc();
        if_rr.core_req_valid_i = 4'b0000;
        cyc();
    endtask

    initial begin
        if_rr.core_req_valid_i = '0;
        if_rr.core_req_abort_i = '0;
        if_rr.core_req_pma_i   = '0;
        if_rr.core_rsp_valid_i = 1'b0;
        if_rr.core_rsp_i       = '0;
        if_rr.arb_req_ready_i  = 1'b0;
        if_fp.core_req_valid_i = '0;
        if_fp.core_req_abort_i = '0;
        if_fp.core_req_pma_i   = '0;
        if_fp.core_rsp_valid_i = 1'b0;
        if_fp.core_rsp_i       = '0;
        if_fp.arb_req_ready_i  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_rr.core_req_i[i]     = '{addr: 16'h0100 + 16'(i), wdata: 32'h0, op: 4'd1, sid: 4'(i), tid: 4'd0};
            if_fp.core_req_i[i]     = '{addr: 16'h0200 + 16'(i), wdata: 32'h0, op: 4'd1, sid: 4'(i), tid: 4'd0};
            if_rr.core_req_tag_i[i] = 24'h000011 * 24'(i + 3);
            if_fp.core_req_tag_i[i] = 24'h0;
        end
        test_reset();
        test_rr_rotation();
        test_stall_hold();
        test_second_cycle();
        test_rsp_routing();
        test_fixed_priority();
        test_reset_during_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
